// File: rtl/demux_pkg.sv
// Shared constants and helpers for the buffered 1-to-4 word demultiplexer.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package demux_pkg;

  localparam int NUM_CH    = 4;
  localparam int SEL_W     = 2;
  localparam int DEF_WIDTH = 32;
  localparam int DEF_DEPTH = 2;

  // Ceiling log2, used to size FIFO pointers (DEPTH is a power of two >= 2).
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/chan_fifo.sv
// Single-channel synchronous FIFO with registered storage; head word read straight from storage.
// Latency: a word pushed at edge k is visible (empty low) in the cycle after edge k; no bypass.
// Backpressure: push ignored while full, pop ignored while empty; a pop frees space only at the next edge.
module chan_fifo
  import demux_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic             empty,
  output logic             full
);

  localparam int PW = clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    cnt_q;
  logic             do_push, do_pop;

  assign full    = (cnt_q == CW'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Head word is the stored entry at the read pointer.
  assign head_data = mem_q[rd_ptr_q];

  // Storage, pointers and occupancy; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= push_data;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (do_pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/demux_1_4_32_buf.sv
// Buffered 1-to-4 demux: steers a word stream into one of four channel FIFOs (DEMUX_BROADCAST_EN adds broadcast to all four).
// Latency: one cycle from accepted push to out_valid of the destination channel; no bypass.
// Backpressure: in_ready = enable && destination not full (all channels not full when broadcasting); independent of out_ready.
module demux_1_4_32_buf
  import demux_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WIDTH-1:0]  in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [SEL_W-1:0]  select,
  input  logic              enable,
  input  logic              bcast,
  output logic [WIDTH-1:0]  data_out_0,
  output logic [WIDTH-1:0]  data_out_1,
  output logic [WIDTH-1:0]  data_out_2,
  output logic [WIDTH-1:0]  data_out_3,
  output logic [NUM_CH-1:0] out_valid,
  input  logic [NUM_CH-1:0] out_ready
);

  logic [NUM_CH-1:0] push, pop, empty, full;
  logic [WIDTH-1:0]  head [NUM_CH];

`ifndef DEMUX_BROADCAST_EN
  // Broadcast request has no effect in the select-only build.
  logic unused_bcast;
  assign unused_bcast = bcast;
`endif

  // Ready and push steering; in_ready is held low while reset is asserted.
  always_comb begin
    in_ready = 1'b0;
    push     = '0;
`ifdef DEMUX_BROADCAST_EN
    if (bcast) begin
      in_ready = !rst && enable && !(|full);
      if (in_valid && in_ready) push = '1;
    end else begin
      in_ready = !rst && enable && !full[select];
      if (in_valid && in_ready) push[select] = 1'b1;
    end
`else
    in_ready = !rst && enable && !full[select];
    if (in_valid && in_ready) push[select] = 1'b1;
`endif
  end

  assign pop       = out_ready & out_valid;
  assign out_valid = ~empty;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    chan_fifo #(
      .WIDTH(WIDTH),
      .DEPTH(DEPTH)
    ) u_fifo (
      .clk      (clk),
      .rst      (rst),
      .push     (push[g]),
      .push_data(in_data),
      .pop      (pop[g]),
      .head_data(head[g]),
      .empty    (empty[g]),
      .full     (full[g])
    );
  end

  assign data_out_0 = head[0];
  assign data_out_1 = head[1];
  assign data_out_2 = head[2];
  assign data_out_3 = head[3];

endmodule

// File: tb/tb_demux_1_4_32_buf.sv
// Directed bench for the buffered 1-to-4 demux (broadcast steps compiled when DEMUX_BROADCAST_EN is defined).
// Inputs driven on the falling edge, outputs sampled on the falling edge after the rising edge acts.
// Expected values are hand-computed constants per step.
module tb_demux_1_4_32_buf;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  select;
  logic        enable;
  logic        bcast;
  logic [31:0] data_out_0, data_out_1, data_out_2, data_out_3;
  logic [3:0]  out_valid;
  logic [3:0]  out_ready;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  demux_1_4_32_buf dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .select    (select),
    .enable    (enable),
    .bcast     (bcast),
    .data_out_0(data_out_0),
    .data_out_1(data_out_1),
    .data_out_2(data_out_2),
    .data_out_3(data_out_3),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One rising edge, then return at the following falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    rst       = 1'b1;
    in_data   = '0;
    in_valid  = 1'b0;
    select    = 2'd0;
    enable    = 1'b1;
    bcast     = 1'b0;
    out_ready = 4'b0000;

    // Reset state
    #3;
    chk("in_ready_in_reset", {31'd0, in_ready}, 32'd0);
    step();
    step();
    rst = 1'b0;
    #1;
    chk("rst_out_valid", {28'd0, out_valid}, 32'h0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_data_out_0", data_out_0, 32'h0);
    chk("rst_data_out_1", data_out_1, 32'h0);
    chk("rst_data_out_2", data_out_2, 32'h0);
    chk("rst_data_out_3", data_out_3, 32'h0);

    // Single push to channel 2
    @(negedge clk);
    in_valid = 1'b1; in_data = 32'hA5A5_0001; select = 2'd2;
    step();
    in_valid = 1'b0;
    chk("ch2_out_valid", {28'd0, out_valid}, 32'h4);
    chk("ch2_data", data_out_2, 32'hA5A5_0001);
    chk("ch2_other0", data_out_0, 32'h0);
    chk("ch2_other1", data_out_1, 32'h0);
    chk("ch2_other3", data_out_3, 32'h0);
    step();
    chk("ch2_held", {28'd0, out_valid}, 32'h4);
    out_ready = 4'b0100;
    step();
    out_ready = 4'b0000;
    chk("ch2_drained", {28'd0, out_valid}, 32'h0);

    // Fill channel 1, third word waits for space
    select = 2'd1; in_valid = 1'b1; in_data = 32'd1;
    step();
    in_data = 32'd2;
    step();
    chk("ch1_full_ready", {31'd0, in_ready}, 32'd0);
    select = 2'd0;
    #1;
    chk("ch0_ready_while_ch1_full", {31'd0, in_ready}, 32'd1);
    select = 2'd1; in_data = 32'd3;
    #1;
    chk("ch1_head_1", data_out_1, 32'd1);
    out_ready = 4'b0010;
    step();
    chk("ch1_head_2", data_out_1, 32'd2);
    chk("ch1_space_ready", {31'd0, in_ready}, 32'd1);
    step();
    in_valid = 1'b0;
    chk("ch1_head_3", data_out_1, 32'd3);
    chk("ch1_valid_3", {31'd0, out_valid[1]}, 32'd1);
    step();
    out_ready = 4'b0000;
    chk("ch1_drained", {28'd0, out_valid}, 32'h0);

    // Channel 3 full: simultaneous pop and refused push
    select = 2'd3; in_valid = 1'b1; in_data = 32'h31;
    step();
    in_data = 32'h32;
    step();
    in_data = 32'h33; out_ready = 4'b1000;
    #1;
    chk("ch3_full_ready", {31'd0, in_ready}, 32'd0);
    step();
    out_ready = 4'b0000;
    chk("ch3_after_pop_head", data_out_3, 32'h32);
    chk("ch3_after_pop_ready", {31'd0, in_ready}, 32'd1);
    step();
    in_valid = 1'b0;
    chk("ch3_full_again", {31'd0, in_ready}, 32'd0);
    chk("ch3_head_still_32", data_out_3, 32'h32);
    out_ready = 4'b1000;
    step();
    chk("ch3_head_33", data_out_3, 32'h33);
    step();
    out_ready = 4'b0000;
    chk("ch3_drained", {28'd0, out_valid}, 32'h0);

    // enable low: no pushes, channel 0 still drains
    select = 2'd0; in_valid = 1'b1; in_data = 32'h11;
    step();
    in_data = 32'h22;
    step();
    enable = 1'b0; select = 2'd1; in_data = 32'h99; out_ready = 4'b0001;
    #1;
    chk("en0_ready", {31'd0, in_ready}, 32'd0);
    chk("en0_head_11", data_out_0, 32'h11);
    step();
    chk("en0_head_22", data_out_0, 32'h22);
    chk("en0_ready_c1", {31'd0, in_ready}, 32'd0);
    step();
    chk("en0_empty_c2", {28'd0, out_valid}, 32'h0);
    step();
    step();
    chk("en0_empty_c4", {28'd0, out_valid}, 32'h0);
    in_valid = 1'b0; enable = 1'b1; out_ready = 4'b0000;

`ifdef DEMUX_BROADCAST_EN
    // Broadcast into all-empty channels
    bcast = 1'b1; select = 2'd1; in_valid = 1'b1; in_data = 32'hDEAD_BEEF;
    step();
    in_valid = 1'b0;
    chk("bc_out_valid", {28'd0, out_valid}, 32'hF);
    chk("bc_d0", data_out_0, 32'hDEAD_BEEF);
    chk("bc_d1", data_out_1, 32'hDEAD_BEEF);
    chk("bc_d2", data_out_2, 32'hDEAD_BEEF);
    chk("bc_d3", data_out_3, 32'hDEAD_BEEF);
    out_ready = 4'b1111;
    step();
    out_ready = 4'b0000; bcast = 1'b0; select = 2'd0; in_valid = 1'b1; in_data = 32'h41;
    step();
    in_data = 32'h42;
    step();
    // Broadcast blocked by full channel 0
    bcast = 1'b1; in_data = 32'h55;
    #1;
    chk("bc_blocked_ready", {31'd0, in_ready}, 32'd0);
    step();
    in_valid = 1'b0; bcast = 1'b0;
    chk("bc_blocked_valid", {28'd0, out_valid}, 32'h1);
    chk("bc_blocked_head0", data_out_0, 32'h41);
    out_ready = 4'b0001;
    step();
    step();
    out_ready = 4'b0000;
`else
    // bcast is ignored: word goes only to the selected channel
    bcast = 1'b1; select = 2'd2; in_valid = 1'b1; in_data = 32'h77;
    step();
    in_valid = 1'b0; bcast = 1'b0;
    chk("nobc_out_valid", {28'd0, out_valid}, 32'h4);
    chk("nobc_d2", data_out_2, 32'h77);
    out_ready = 4'b0100;
    step();
    out_ready = 4'b0000;
`endif
    chk("pre_rst_empty", {28'd0, out_valid}, 32'h0);

    // Asynchronous reset between clock edges
    select = 2'd0; in_valid = 1'b1; in_data = 32'h61;
    step();
    select = 2'd3; in_data = 32'h63;
    step();
    in_valid = 1'b0;
    chk("pre_arst_valid", {28'd0, out_valid}, 32'h9);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_valid_now", {28'd0, out_valid}, 32'h0);
    chk("arst_ready_now", {31'd0, in_ready}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("arst_d0_cleared", data_out_0, 32'h0);
    chk("arst_d3_cleared", data_out_3, 32'h0);
    step();
    chk("arst_stays_empty", {28'd0, out_valid}, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
